// File: rtl/meter_countdown.sv
// Remaining-time register, once-per-second countdown, expiry/low status and display blink.
// Optional BCD image of time_left is built only when METER_COUNTDOWN_BCD_EN is defined.
//
// state      | meaning
// ST_EXPIRED | time_left == 0, display blinks on the tick_20hz divider
// ST_LOW     | 0 < time_left < LOW_THRESH, display toggles every tick_1hz
// ST_RUN     | time_left >= LOW_THRESH, display steady on
module meter_countdown #(
  parameter int MAX_TIME      = 9999,
  parameter int LOW_THRESH    = 200,
  parameter int EXP_BLINK_DIV = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_1hz,
  input  logic        tick_20hz,
  input  logic [13:0] time_in,
  output logic [13:0] time_left,
  output logic        expired,
  output logic        low_warn,
  output logic        display_on,
  output logic [15:0] bcd,
  output logic        bcd_valid
);

  typedef enum logic [1:0] {ST_EXPIRED, ST_LOW, ST_RUN} state_t;

  localparam logic [13:0] LP_MAX      = 14'(MAX_TIME);
  localparam logic [13:0] LP_LOW      = 14'(LOW_THRESH);
  localparam logic [7:0]  LP_DIV_LAST = 8'(EXP_BLINK_DIV - 1);

  logic [13:0] r_time_left;
  logic [13:0] w_load;
  logic [13:0] w_base;
  logic [13:0] w_time_nxt;
  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_display_on;
  logic        w_disp_nxt;
  logic [7:0]  r_blink_div;
  logic [7:0]  w_div_nxt;

  assign w_load = (time_in > LP_MAX) ? LP_MAX : time_in;

  // A same-cycle load and decrement applies the decrement to the freshly loaded value.
  always_comb begin
    w_base     = tick_20hz ? w_load : r_time_left;
    w_time_nxt = w_base;
    if (tick_1hz && (w_base != 14'd0)) w_time_nxt = w_base - 14'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_time_left  <= 14'd0;
      r_state      <= ST_EXPIRED;
      r_display_on <= 1'b1;
      r_blink_div  <= 8'd0;
    end else begin
      r_time_left  <= w_time_nxt;
      r_state      <= w_state_nxt;
      r_display_on <= w_disp_nxt;
      r_blink_div  <= w_div_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_disp_nxt  = r_display_on;
    w_div_nxt   = r_blink_div;
    if (r_time_left == 14'd0)     w_state_nxt = ST_EXPIRED;
    else if (r_time_left < LP_LOW) w_state_nxt = ST_LOW;
    else                           w_state_nxt = ST_RUN;

    if (w_state_nxt != r_state) begin
      w_disp_nxt = 1'b1;
      w_div_nxt  = 8'd0;
    end else begin
      case (r_state)
        ST_RUN:     w_disp_nxt = 1'b1;
        ST_LOW:     if (tick_1hz) w_disp_nxt = ~r_display_on;
        ST_EXPIRED: begin
          if (tick_20hz) begin
            if (r_blink_div == LP_DIV_LAST) begin
              w_div_nxt  = 8'd0;
              w_disp_nxt = ~r_display_on;
            end else begin
              w_div_nxt  = r_blink_div + 8'd1;
            end
          end
        end
        default:    w_disp_nxt = 1'b1;
      endcase
    end
  end

  assign time_left  = r_time_left;
  assign expired    = (r_state == ST_EXPIRED);
  assign low_warn   = (r_state == ST_LOW);
  assign display_on = r_display_on;

`ifdef METER_COUNTDOWN_BCD_EN
  logic [29:0] r_shift;
  logic [29:0] w_adj;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic [13:0] r_prev_time;
  logic [15:0] r_bcd;
  logic        r_bcd_valid;

  // Shift-add-3: digits live in [29:14], the binary value shifts out of [13:0].
  always_comb begin
    w_adj = r_shift;
    for (int i = 0; i < 4; i++) begin
      if (r_shift[14 + 4*i +: 4] >= 4'd5) w_adj[14 + 4*i +: 4] = r_shift[14 + 4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= 30'd0;
      r_cnt       <= 4'd0;
      r_busy      <= 1'b0;
      r_prev_time <= 14'd0;
      r_bcd       <= 16'h0000;
      r_bcd_valid <= 1'b1;
    end else begin
      r_prev_time <= r_time_left;
      if (r_time_left != r_prev_time) begin
        r_shift     <= {16'd0, r_time_left};
        r_cnt       <= 4'd14;
        r_busy      <= 1'b1;
        r_bcd_valid <= 1'b0;
      end else if (r_busy) begin
        if (r_cnt != 4'd0) begin
          r_shift <= w_adj << 1;
          r_cnt   <= r_cnt - 4'd1;
        end else begin
          r_bcd       <= r_shift[29:14];
          r_bcd_valid <= 1'b1;
          r_busy      <= 1'b0;
        end
      end
    end
  end

  assign bcd       = r_bcd;
  assign bcd_valid = r_bcd_valid;
`else
  assign bcd       = 16'h0000;
  assign bcd_valid = 1'b0;
`endif

endmodule

// File: tb/tb_meter_countdown.sv
// Scoreboard bench for meter_countdown: a driver updates a reference model and queues
// the expected outputs per edge; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_meter_countdown;

  localparam int MAX_TIME      = 9999;
  localparam int LOW_THRESH    = 200;
  localparam int EXP_BLINK_DIV = 5;
  localparam int CAT_EXP = 0, CAT_LOW = 1, CAT_RUN = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_1hz = 1'b0;
  logic        tick_20hz = 1'b0;
  logic [13:0] time_in = 14'd0;
  logic [13:0] time_left;
  logic        expired, low_warn, display_on, bcd_valid;
  logic [15:0] bcd;

  meter_countdown #(.MAX_TIME(MAX_TIME), .LOW_THRESH(LOW_THRESH), .EXP_BLINK_DIV(EXP_BLINK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_20hz(tick_20hz), .time_in(time_in),
    .time_left(time_left), .expired(expired), .low_warn(low_warn), .display_on(display_on),
    .bcd(bcd), .bcd_valid(bcd_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_no;
    logic [13:0] tl;
    logic        exp_f;
    logic        low_f;
    logic        disp;
    logic [15:0] bcd_v;
    logic        bv;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_miss = 0;

  // reference model state
  int m_tl = 0, m_cat = CAT_EXP, m_div = 0, m_k = 0, m_last = -1000, m_lastval = 0;
  logic m_disp = 1'b1, m_valid = 1'b1;
  logic [15:0] m_bcd = 16'h0000;

  function automatic int cat_of(input int v);
    if (v == 0) return CAT_EXP;
    if (v < LOW_THRESH) return CAT_LOW;
    return CAT_RUN;
  endfunction

  function automatic logic [15:0] digits(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_tl = 0; m_cat = CAT_EXP; m_div = 0; m_disp = 1'b1;
    m_bcd = 16'h0000; m_valid = 1'b1; m_last = -1000; m_lastval = 0;
  endtask

  task automatic model_step(input bit t1, input bit t20, input int tin);
    int old_tl, new_tl, c, age;
    old_tl = m_tl;
    new_tl = old_tl;
    if (t20) new_tl = (tin > MAX_TIME) ? MAX_TIME : tin;
    if (t1 && new_tl > 0) new_tl = new_tl - 1;

    c = cat_of(old_tl);
    if (c != m_cat) begin
      m_cat = c; m_disp = 1'b1; m_div = 0;
    end else if (m_cat == CAT_LOW && t1) begin
      m_disp = ~m_disp;
    end else if (m_cat == CAT_EXP && t20) begin
      m_div = m_div + 1;
      if (m_div == EXP_BLINK_DIV) begin
        m_div = 0; m_disp = ~m_disp;
      end
    end

    // conversion result lands 16 edges after the most recent change; invalid for the 15 edges in between
    age = m_k - m_last;
    m_valid = !(age >= 1 && age <= 15);
    if (age == 16) m_bcd = digits(m_lastval);
    if (new_tl != old_tl) begin
      m_last = m_k; m_lastval = new_tl;
    end
    m_tl = new_tl;
  endtask

  task automatic drive(input bit rst, input bit t1, input bit t20, input int tin);
    exp_t e;
    @(negedge clk);
    #1;
    rst_n = rst; tick_1hz = t1; tick_20hz = t20; time_in = 14'(tin);
    if (!rst) model_reset();
    else model_step(t1, t20, tin);
    e.edge_no = m_k;
    e.tl = 14'(m_tl);
    e.exp_f = (m_cat == CAT_EXP);
    e.low_f = (m_cat == CAT_LOW);
    e.disp = m_disp;
`ifdef METER_COUNTDOWN_BCD_EN
    e.bcd_v = m_bcd;
    e.bv = m_valid;
`else
    e.bcd_v = 16'h0000;
    e.bv = 1'b0;
`endif
    q.push_back(e);
    m_k++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      bit bad;
      e = q.pop_front();
      bad = 1'b0;
      n_vec++;
      if (time_left !== e.tl) begin
        bad = 1'b1; $display("FAIL time_left edge %0d: got %0d want %0d", e.edge_no, time_left, e.tl);
      end
      if (expired !== e.exp_f) begin
        bad = 1'b1; $display("FAIL expired edge %0d: got %b want %b", e.edge_no, expired, e.exp_f);
      end
      if (low_warn !== e.low_f) begin
        bad = 1'b1; $display("FAIL low_warn edge %0d: got %b want %b", e.edge_no, low_warn, e.low_f);
      end
      if (display_on !== e.disp) begin
        bad = 1'b1; $display("FAIL display_on edge %0d: got %b want %b", e.edge_no, display_on, e.disp);
      end
      if (bcd !== e.bcd_v) begin
        bad = 1'b1; $display("FAIL bcd edge %0d: got %h want %h", e.edge_no, bcd, e.bcd_v);
      end
      if (bcd_valid !== e.bv) begin
        bad = 1'b1; $display("FAIL bcd_valid edge %0d: got %b want %b", e.edge_no, bcd_valid, e.bv);
      end
      if (bad) n_miss++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int mode, r, v;
    bit t1, t20, rs;
    mode = 0;
    drive(1'b0, 1'b0, 1'b0, 0);
    drive(1'b0, 1'b0, 1'b0, 0);

    // idle expired blink: 20 tick_20hz with time_in=0
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 1'b1, 0);
      drive(1'b1, 1'b0, 1'b0, 0);
    end

    // load 205, three seconds of countdown with full conversions between
    drive(1'b1, 1'b0, 1'b1, 205);
    idle(20);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 0);
      idle(20);
    end

    // threshold crossing and low blink
    drive(1'b1, 1'b0, 1'b1, 200);
    idle(3);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 0);
      idle(3);
    end

    // expiry and no wrap
    drive(1'b1, 1'b0, 1'b1, 1);
    idle(2);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 0);
      idle(2);
    end

    // clamp, simultaneous load/decrement, conversion restart
    drive(1'b1, 1'b0, 1'b1, 12000);
    idle(20);
    drive(1'b1, 1'b1, 1'b1, 550);
    idle(20);
    drive(1'b1, 1'b0, 1'b1, 300);
    idle(4);
    drive(1'b1, 1'b0, 1'b1, 400);
    idle(20);

    // reset mid-conversion
    drive(1'b1, 1'b0, 1'b1, 4321);
    idle(6);
    drive(1'b0, 1'b0, 1'b0, 0);
    idle(20);

    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) mode = $urandom_range(0, 3);
      t1 = ($urandom_range(0, 3) == 0);
      t20 = ($urandom_range(0, (mode == 0) ? 2 : ((mode == 3) ? 1 : 40)) == 0);
      r = $urandom_range(0, 7);
      case (r)
        0: v = 0;
        1: v = 1;
        2: v = $urandom_range(LOW_THRESH - 2, LOW_THRESH + 2);
        3: v = $urandom_range(0, 16383);
        4: v = $urandom_range(10000, 16383);
        5: v = MAX_TIME;
        default: v = $urandom_range(0, 400);
      endcase
      if (mode == 3) v = 0;
      rs = ($urandom_range(0, 999) != 0);
      drive(rs, t1, t20, v);
    end

    idle(20);
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending vectors, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
